gpio_in_port: RTL



---
 rtl/gpio_in_pkg.sv | 19 +
 rtl/gpio_in_debounce.sv | 54 +++++
 rtl/gpio_in_port.sv | 91 +++++++++
 3 files changed

// File: rtl/gpio_in_pkg.sv
// Shared constants and types for the gpio_in_port input peripheral.
package gpio_in_pkg;

    localparam logic [1:0] GPIO_IN_DATA = 2'd0;
    localparam logic [1:0] GPIO_IN_EDGE = 2'd1;
    localparam logic [1:0] GPIO_IN_MASK = 2'd2;
    localparam logic [1:0] GPIO_IN_POL  = 2'd3;

    localparam int DB_PRESCALE_W = 16;
    localparam int NUM_PINS      = 8;

    typedef struct packed {
        logic       cs;
        logic       we;
        logic [1:0] addr;
        logic [7:0] din;
    } gpio_in_req_t;

endpackage

// File: rtl/gpio_in_debounce.sv
// Debounce filter: shared sample-tick prescaler plus a per-pin stable counter.
module gpio_in_debounce
    import gpio_in_pkg::*;
#(
    parameter int NUM_BITS = 8,
    parameter int PRESCALE = 16000,
    parameter int STABLE   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BITS-1:0] sync,
    output logic [NUM_BITS-1:0] lvl
);

    localparam logic [DB_PRESCALE_W-1:0] PRE_MAX = DB_PRESCALE_W'(PRESCALE - 1);
    localparam logic [3:0]               STB_MAX = 4'(STABLE - 1);

    logic [DB_PRESCALE_W-1:0] pre_cnt;
    logic                     tick;

    assign tick = (pre_cnt == PRE_MAX);

    always_ff @(posedge clk) begin
        if (reset)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    for (genvar g = 0; g < NUM_BITS; g++) begin : g_bit
        logic [3:0] stb_cnt;
        logic       lvl_q;

        // The counter holds how many earlier ticks already disagreed, so the
        // level flips on the STABLE-th consecutive differing tick.
        always_ff @(posedge clk) begin
            if (reset) begin
                stb_cnt <= '0;
                lvl_q   <= 1'b0;
            end else if (tick) begin
                if (sync[g] == lvl_q) begin
                    stb_cnt <= '0;
                end else if (stb_cnt == STB_MAX) begin
                    lvl_q   <= sync[g];
                    stb_cnt <= '0;
                end else begin
                    stb_cnt <= stb_cnt + 1'b1;
                end
            end
        end

        assign lvl[g] = lvl_q;
    end

endmodule

// File: rtl/gpio_in_port.sv
// CPU-bus GPIO input port: sync, optional debounce (GPIO_IN_DEBOUNCE_EN),
// edge detect into W1C sticky flags, maskable level interrupt.
module gpio_in_port
    import gpio_in_pkg::*;
#(
    parameter int DB_PRESCALE = 16000,
    parameter int DB_STABLE   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] gpio_i,
    output logic       irq
);

    if (DB_PRESCALE < 2 || DB_PRESCALE > 65535 || DB_STABLE < 2 || DB_STABLE > 15) begin : g_bad_param
        $error("gpio_in_port: DB_PRESCALE or DB_STABLE out of range");
    end

    gpio_in_req_t              req;
    logic [1:0][NUM_PINS-1:0]  sync_pipe;
    logic [NUM_PINS-1:0]       sync, lvl, lvl_d;
    logic [NUM_PINS-1:0]       rise, fall, ev, clr;
    logic [NUM_PINS-1:0]       edge_q, mask_q, pol_q;
    logic [NUM_PINS-1:0]       rd_data;
    logic                      wr_en, rd_en;

    assign req   = '{cs: cs, we: we, addr: addr, din: din};
    assign wr_en = req.cs & req.we;
    assign rd_en = req.cs & ~req.we;

    always_ff @(posedge clk) begin
        if (reset) sync_pipe <= '0;
        else       sync_pipe <= {sync_pipe[0], gpio_i};
    end
    assign sync = sync_pipe[1];

`ifdef GPIO_IN_DEBOUNCE_EN
    gpio_in_debounce #(
        .NUM_BITS (NUM_PINS),
        .PRESCALE (DB_PRESCALE),
        .STABLE   (DB_STABLE)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .sync  (sync),
        .lvl   (lvl)
    );
`else
    assign lvl = sync;
`endif

    // Events come only from level transitions, so rewriting POL never fires one.
    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;
    assign ev   = (pol_q & fall) | (~pol_q & rise);
    assign clr  = (wr_en && req.addr == GPIO_IN_EDGE) ? req.din : '0;

    always_comb begin
        rd_data = lvl;
        case (req.addr)
            GPIO_IN_EDGE: rd_data = edge_q;
            GPIO_IN_MASK: rd_data = mask_q;
            GPIO_IN_POL:  rd_data = pol_q;
            default:      rd_data = lvl;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_d  <= '0;
            edge_q <= '0;
            mask_q <= '0;
            pol_q  <= '0;
            dout   <= '0;
            irq    <= 1'b0;
        end else begin
            lvl_d  <= lvl;
            edge_q <= (edge_q & ~clr) | ev;
            irq    <= |(edge_q & mask_q);
            if (wr_en && req.addr == GPIO_IN_MASK) mask_q <= req.din;
            if (wr_en && req.addr == GPIO_IN_POL)  pol_q  <= req.din;
            if (rd_en) dout <= rd_data;
        end
    end

endmodule
